// File: rtl/branch_predict_unit.sv
// Branch predictor and misprediction resolver: direct-mapped BHT of saturating counters plus a
// tagged BTB feeding IF, with a prediction record pipeline resolved in EX.
module branch_predict_unit #(
  parameter int unsigned IDX_W  = 6,
  parameter int unsigned CNT_W  = 2,
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned STAT_W = 32
) (
  input  logic              cpu_clk,
  input  logic              cpu_rst,
  input  logic [31:0]       pc_IF,
  input  logic              stall,
  input  logic              is_B_EX,
  input  logic              real_br_EX,
  input  logic [31:0]       pc_EX,
  input  logic [31:0]       pc4_EX,
  input  logic [31:0]       ext_EX,
  output logic              pred_br,
  output logic [31:0]       pred_pc,
  output logic              Flush_B,
  output logic [31:0]       br_pc,
  output logic [STAT_W-1:0] br_count,
  output logic [STAT_W-1:0] miss_count
);

  localparam int unsigned ENTRIES = 1 << IDX_W;
  localparam int unsigned TAG_W   = 30 - IDX_W;
  localparam logic [CNT_W-1:0] CntInit = CNT_W'((1 << (CNT_W - 1)) - 1);
  localparam logic [CNT_W-1:0] CntMax  = '1;

  // Prediction tables
  logic [CNT_W-1:0] bht_q       [ENTRIES];
  logic             btb_valid_q [ENTRIES];
  logic [TAG_W-1:0] btb_tag_q   [ENTRIES];
  logic [31:0]      btb_tgt_q   [ENTRIES];

  // Prediction records travelling from IF to EX; index DEPTH-1 is the EX record
  logic             rec_valid_q [DEPTH];
  logic             rec_taken_q [DEPTH];
  logic [31:0]      rec_tgt_q   [DEPTH];

  logic [STAT_W-1:0] br_count_q, miss_count_q;

  logic [IDX_W-1:0] if_idx, ex_idx;
  logic [TAG_W-1:0] if_tag, ex_tag;
  logic             btb_hit;
  logic [31:0]      act_tgt;
  logic             ex_taken;
  logic             mispredict;
  logic             upd_en;
  logic [CNT_W-1:0] cnt_cur, cnt_nxt;
  logic             unused_pc_bits;

  assign if_idx = pc_IF[IDX_W+1:2];
  assign if_tag = pc_IF[31:IDX_W+2];
  assign ex_idx = pc_EX[IDX_W+1:2];
  assign ex_tag = pc_EX[31:IDX_W+2];
  assign unused_pc_bits = ^{pc_IF[1:0], pc_EX[1:0]};

  // IF prediction reads the table state before any same-cycle update
  assign btb_hit = btb_valid_q[if_idx] & (btb_tag_q[if_idx] == if_tag);
  assign pred_br = btb_hit & bht_q[if_idx][CNT_W-1];
  assign pred_pc = pred_br ? btb_tgt_q[if_idx] : pc_IF + 32'd4;

  // EX resolution; an invalid record counts as a not-taken prediction
  assign act_tgt    = pc_EX + ext_EX;
  assign ex_taken   = rec_valid_q[DEPTH-1] & rec_taken_q[DEPTH-1];
  assign mispredict = is_B_EX & ((ex_taken != real_br_EX) |
                                 (real_br_EX & (rec_tgt_q[DEPTH-1] != act_tgt)));
  assign Flush_B    = mispredict & ~stall;
  assign br_pc      = real_br_EX ? act_tgt : pc4_EX;
  assign upd_en     = is_B_EX & ~stall;

  always_comb begin
    cnt_cur = bht_q[ex_idx];
    cnt_nxt = cnt_cur;
    if (real_br_EX) begin
      if (cnt_cur != CntMax) cnt_nxt = cnt_cur + CNT_W'(1);
    end else begin
      if (cnt_cur != '0) cnt_nxt = cnt_cur - CNT_W'(1);
    end
  end

  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        bht_q[i]       <= CntInit;
        btb_valid_q[i] <= 1'b0;
      end
    end else if (upd_en) begin
      bht_q[ex_idx] <= cnt_nxt;
      if (real_br_EX) btb_valid_q[ex_idx] <= 1'b1;
    end
  end

  // Tag and target are qualified by the valid bit, so they need no reset
  always_ff @(posedge cpu_clk) begin
    if (upd_en && real_br_EX) begin
      btb_tag_q[ex_idx] <= ex_tag;
      btb_tgt_q[ex_idx] <= act_tgt;
    end
  end

  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        rec_valid_q[i] <= 1'b0;
        rec_taken_q[i] <= 1'b0;
        rec_tgt_q[i]   <= '0;
      end
    end else if (Flush_B) begin
      for (int i = 0; i < DEPTH; i++) rec_valid_q[i] <= 1'b0;
    end else if (!stall) begin
      rec_valid_q[0] <= 1'b1;
      rec_taken_q[0] <= pred_br;
      rec_tgt_q[0]   <= pred_pc;
      for (int i = 1; i < DEPTH; i++) begin
        rec_valid_q[i] <= rec_valid_q[i-1];
        rec_taken_q[i] <= rec_taken_q[i-1];
        rec_tgt_q[i]   <= rec_tgt_q[i-1];
      end
    end
  end

  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      br_count_q   <= '0;
      miss_count_q <= '0;
    end else if (upd_en) begin
      br_count_q   <= br_count_q + STAT_W'(1);
      miss_count_q <= miss_count_q + STAT_W'(mispredict);
    end
  end

  assign br_count   = br_count_q;
  assign miss_count = miss_count_q;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed self-checking bench for branch_predict_unit with default parameters.
module tb_branch_predict_unit;

  logic        cpu_clk = 1'b0;
  logic        cpu_rst;
  logic [31:0] pc_IF;
  logic        stall;
  logic        is_B_EX;
  logic        real_br_EX;
  logic [31:0] pc_EX;
  logic [31:0] pc4_EX;
  logic [31:0] ext_EX;
  logic        pred_br;
  logic [31:0] pred_pc;
  logic        Flush_B;
  logic [31:0] br_pc;
  logic [31:0] br_count;
  logic [31:0] miss_count;

  int checks = 0;
  int failures = 0;

  branch_predict_unit dut (
    .cpu_clk    (cpu_clk),
    .cpu_rst    (cpu_rst),
    .pc_IF      (pc_IF),
    .stall      (stall),
    .is_B_EX    (is_B_EX),
    .real_br_EX (real_br_EX),
    .pc_EX      (pc_EX),
    .pc4_EX     (pc4_EX),
    .ext_EX     (ext_EX),
    .pred_br    (pred_br),
    .pred_pc    (pred_pc),
    .Flush_B    (Flush_B),
    .br_pc      (br_pc),
    .br_count   (br_count),
    .miss_count (miss_count)
  );

  always #5 cpu_clk = ~cpu_clk;

  task automatic tick();
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic set_br(input logic [31:0] pc, input logic [31:0] ext, input logic taken);
    is_B_EX    = 1'b1;
    pc_EX      = pc;
    pc4_EX     = pc + 32'd4;
    ext_EX     = ext;
    real_br_EX = taken;
  endtask

  task automatic test_reset();
    cpu_rst = 1'b1; pc_IF = 32'h100; stall = 1'b0; is_B_EX = 1'b0; real_br_EX = 1'b0;
    pc_EX = '0; pc4_EX = '0; ext_EX = '0;
    tick(); tick();
    cpu_rst = 1'b0;
    #1;
    checks++;
    if (pred_br !== 1'b0 || pred_pc !== 32'h104) begin
      failures++;
      $display("FAIL reset_pred: pred_br=%b pred_pc=%h, required 0 00000104", pred_br, pred_pc);
    end
    checks++;
    if (Flush_B !== 1'b0 || br_count !== 0 || miss_count !== 0) begin
      failures++;
      $display("FAIL reset_state: flush=%b br=%0d miss=%0d, required 0 0 0",
               Flush_B, br_count, miss_count);
    end
    tick(); tick();
  endtask

  task automatic test_cold_branch();
    pc_IF = 32'h200;
    set_br(32'h100, 32'hFFFF_FFF0, 1'b1);
    #1;
    checks++;
    if (Flush_B !== 1'b1 || br_pc !== 32'hF0) begin
      failures++;
      $display("FAIL cold_flush: flush=%b br_pc=%h, required 1 000000f0", Flush_B, br_pc);
    end
    tick();
    is_B_EX = 1'b0; pc_IF = 32'h100;
    #1;
    checks++;
    if (br_count !== 1 || miss_count !== 1) begin
      failures++;
      $display("FAIL cold_counts: br=%0d miss=%0d, required 1 1", br_count, miss_count);
    end
    checks++;
    if (pred_br !== 1'b1 || pred_pc !== 32'hF0) begin
      failures++;
      $display("FAIL cold_pred: pred_br=%b pred_pc=%h, required 1 000000f0", pred_br, pred_pc);
    end
  endtask

  task automatic test_loop();
    int flushes = 0;
    tick(); tick();
    for (int i = 0; i < 5; i++) begin
      set_br(32'h100, 32'hFFFF_FFF0, 1'b1);
      #1;
      if (Flush_B !== 1'b0) flushes++;
      tick();
    end
    checks++;
    if (flushes !== 0 || br_count !== 6 || miss_count !== 1) begin
      failures++;
      $display("FAIL loop_trained: flushes=%0d br=%0d miss=%0d, required 0 6 1",
               flushes, br_count, miss_count);
    end
    set_br(32'h100, 32'hFFFF_FFF0, 1'b0);
    #1;
    checks++;
    if (Flush_B !== 1'b1 || br_pc !== 32'h104) begin
      failures++;
      $display("FAIL loop_exit_flush: flush=%b br_pc=%h, required 1 00000104", Flush_B, br_pc);
    end
    tick();
    is_B_EX = 1'b0;
    #1;
    checks++;
    if (pred_br !== 1'b1 || pred_pc !== 32'hF0 || br_count !== 7 || miss_count !== 2) begin
      failures++;
      $display("FAIL loop_exit_state: pred_br=%b pred_pc=%h br=%0d miss=%0d, required 1 f0 7 2",
               pred_br, pred_pc, br_count, miss_count);
    end
    // EX record was purged by the flush, so a not-taken outcome agrees with it
    set_br(32'h100, 32'hFFFF_FFF0, 1'b0);
    #1;
    checks++;
    if (Flush_B !== 1'b0) begin
      failures++;
      $display("FAIL loop_nt_invalid_rec: flush=%b, required 0", Flush_B);
    end
    tick();
    is_B_EX = 1'b0;
    #1;
    checks++;
    if (pred_br !== 1'b0 || pred_pc !== 32'h104 || br_count !== 8 || miss_count !== 2) begin
      failures++;
      $display("FAIL loop_weak_nt: pred_br=%b pred_pc=%h br=%0d miss=%0d, required 0 104 8 2",
               pred_br, pred_pc, br_count, miss_count);
    end
  endtask

  task automatic test_alias();
    set_br(32'h100, 32'hFFFF_FFF0, 1'b1);
    #1;
    checks++;
    if (Flush_B !== 1'b1) begin
      failures++;
      $display("FAIL alias_retrain_flush: flush=%b, required 1", Flush_B);
    end
    tick();
    is_B_EX = 1'b0; pc_IF = 32'h200;
    #1;
    checks++;
    if (pred_br !== 1'b0 || pred_pc !== 32'h204) begin
      failures++;
      $display("FAIL alias_tag_miss: pred_br=%b pred_pc=%h, required 0 00000204", pred_br, pred_pc);
    end
    pc_IF = 32'h100;
    #1;
    checks++;
    if (pred_br !== 1'b1 || pred_pc !== 32'hF0) begin
      failures++;
      $display("FAIL alias_orig_hit: pred_br=%b pred_pc=%h, required 1 000000f0", pred_br, pred_pc);
    end
    set_br(32'h200, 32'h40, 1'b1);
    #1;
    checks++;
    if (Flush_B !== 1'b1 || br_pc !== 32'h240) begin
      failures++;
      $display("FAIL alias_replace_flush: flush=%b br_pc=%h, required 1 00000240", Flush_B, br_pc);
    end
    tick();
    is_B_EX = 1'b0;
    #1;
    checks++;
    if (pred_br !== 1'b0 || pred_pc !== 32'h104 || br_count !== 10 || miss_count !== 4) begin
      failures++;
      $display("FAIL alias_evicted: pred_br=%b pred_pc=%h br=%0d miss=%0d, required 0 104 10 4",
               pred_br, pred_pc, br_count, miss_count);
    end
    pc_IF = 32'h200;
    #1;
    checks++;
    if (pred_br !== 1'b1 || pred_pc !== 32'h240) begin
      failures++;
      $display("FAIL alias_new_hit: pred_br=%b pred_pc=%h, required 1 00000240", pred_br, pred_pc);
    end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    set_br(32'h40, 32'h8, 1'b1);
    #1;
    checks++;
    if (Flush_B !== 1'b0) begin
      failures++;
      $display("FAIL stall_no_flush: flush=%b, required 0", Flush_B);
    end
    tick(); tick();
    pc_IF = 32'h40;
    #1;
    checks++;
    if (Flush_B !== 1'b0 || pred_br !== 1'b0 || pred_pc !== 32'h44 ||
        br_count !== 10 || miss_count !== 4) begin
      failures++;
      $display("FAIL stall_hold: flush=%b pred_br=%b pred_pc=%h br=%0d miss=%0d, required 0 0 44 10 4",
               Flush_B, pred_br, pred_pc, br_count, miss_count);
    end
    stall = 1'b0;
    #1;
    checks++;
    if (Flush_B !== 1'b1 || br_pc !== 32'h48) begin
      failures++;
      $display("FAIL stall_release_flush: flush=%b br_pc=%h, required 1 00000048", Flush_B, br_pc);
    end
    tick();
    is_B_EX = 1'b0;
    #1;
    checks++;
    if (Flush_B !== 1'b0 || pred_br !== 1'b1 || pred_pc !== 32'h48 ||
        br_count !== 11 || miss_count !== 5) begin
      failures++;
      $display("FAIL stall_after: flush=%b pred_br=%b pred_pc=%h br=%0d miss=%0d, required 0 1 48 11 5",
               Flush_B, pred_br, pred_pc, br_count, miss_count);
    end
  endtask

  task automatic test_flush_purge();
    tick(); tick();
    set_br(32'h40, 32'h10, 1'b1);
    #1;
    checks++;
    if (Flush_B !== 1'b1 || br_pc !== 32'h50) begin
      failures++;
      $display("FAIL purge_target_miss: flush=%b br_pc=%h, required 1 00000050", Flush_B, br_pc);
    end
    tick();
    set_br(32'h40, 32'h10, 1'b0);
    #1;
    checks++;
    if (Flush_B !== 1'b0) begin
      failures++;
      $display("FAIL purge_nt: flush=%b, required 0", Flush_B);
    end
    tick();
    set_br(32'h40, 32'h10, 1'b1);
    #1;
    checks++;
    if (Flush_B !== 1'b1 || br_pc !== 32'h50) begin
      failures++;
      $display("FAIL purge_taken: flush=%b br_pc=%h, required 1 00000050", Flush_B, br_pc);
    end
    tick();
    is_B_EX = 1'b0; real_br_EX = 1'b1;
    #1;
    checks++;
    if (Flush_B !== 1'b0) begin
      failures++;
      $display("FAIL non_branch_flush: flush=%b, required 0", Flush_B);
    end
    tick();
    checks++;
    if (br_count !== 14 || miss_count !== 7) begin
      failures++;
      $display("FAIL purge_counts: br=%0d miss=%0d, required 14 7", br_count, miss_count);
    end
  endtask

  task automatic test_reset_mid();
    #2;
    cpu_rst = 1'b1;
    #1;
    checks++;
    if (br_count !== 0 || miss_count !== 0 || pred_br !== 1'b0 || pred_pc !== 32'h44 ||
        Flush_B !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid: br=%0d miss=%0d pred_br=%b pred_pc=%h flush=%b, required 0 0 0 44 0",
               br_count, miss_count, pred_br, pred_pc, Flush_B);
    end
    tick();
    cpu_rst = 1'b0;
    tick();
    checks++;
    if (Flush_B !== 1'b0 || br_count !== 0) begin
      failures++;
      $display("FAIL reset_release: flush=%b br=%0d, required 0 0", Flush_B, br_count);
    end
  endtask

  task automatic test_sat_low();
    int flushes = 0;
    pc_IF = 32'h300;
    for (int i = 0; i < 2; i++) begin
      set_br(32'h80, 32'h20, 1'b0);
      #1;
      if (Flush_B !== 1'b0) flushes++;
      tick();
    end
    checks++;
    if (flushes !== 0 || br_count !== 2 || miss_count !== 0) begin
      failures++;
      $display("FAIL sat_low_nt: flushes=%0d br=%0d miss=%0d, required 0 2 0",
               flushes, br_count, miss_count);
    end
    set_br(32'h80, 32'h20, 1'b1);
    #1;
    checks++;
    if (Flush_B !== 1'b1 || br_pc !== 32'hA0) begin
      failures++;
      $display("FAIL sat_low_taken: flush=%b br_pc=%h, required 1 000000a0", Flush_B, br_pc);
    end
    tick();
    is_B_EX = 1'b0; pc_IF = 32'h80;
    #1;
    checks++;
    if (pred_br !== 1'b0 || pred_pc !== 32'h84 || br_count !== 3 || miss_count !== 1) begin
      failures++;
      $display("FAIL sat_low_pred: pred_br=%b pred_pc=%h br=%0d miss=%0d, required 0 84 3 1",
               pred_br, pred_pc, br_count, miss_count);
    end
  endtask

  initial begin
    test_reset();
    test_cold_branch();
    test_loop();
    test_alias();
    test_stall();
    test_flush_purge();
    test_reset_mid();
    test_sat_low();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/branch_predict_unit.md
Name: branch_predict_unit

Overview:
- Parametrised successor to the single-bit misprediction handler: a predictor and misprediction resolver for the miniRV pipeline.
- Holds a direct-mapped BHT of saturating counters and a tagged BTB; drives IF next-PC prediction.
- Carries each prediction down an IF→EX record pipeline, resolves in EX, flushes and redirects on mispredict, updates tables and keeps statistics.

Parameters:
- IDX_W, 6, BHT/BTB index width; table depth = 2**IDX_W entries.
- CNT_W, 2, saturating counter width (≥1); predict taken when counter MSB = 1.
- DEPTH, 2, pipeline stages between IF sample and EX resolution (≥1).
- STAT_W, 32, statistics counter width.

Ports:
- cpu_clk  in  1  clock
- cpu_rst  in  1  reset, asynchronous, active-high
- pc_IF  in  32  PC currently fetched
- stall  in  1  pipeline stall; record pipeline and tables hold
- is_B_EX  in  1  EX holds a conditional branch
- real_br_EX  in  1  EX branch outcome (1 = taken)
- pc_EX  in  32  EX instruction PC
- pc4_EX  in  32  EX PC+4
- ext_EX  in  32  EX sign-extended branch offset
- pred_br  out  1  IF prediction: taken
- pred_pc  out  32  IF next fetch PC (BTB target if pred_br, else pc_IF+4)
- Flush_B  out  1  flush IF..ID, redirect to br_pc
- br_pc  out  32  corrected PC: real_br_EX ? pc_EX+ext_EX : pc4_EX
- br_count  out  STAT_W  resolved branches
- miss_count  out  STAT_W  mispredictions

Behaviour:
- Reset (async): BHT counters = 2**(CNT_W-1)-1 (weakly not-taken); BTB valid = 0; record pipeline valid = 0; br_count = miss_count = 0.
- After reset, Flush_B = 0 and pred_br = 0 in the same cycle, because no BTB entry is valid.
- Index = pc[IDX_W+1:2]; tag = pc[31:IDX_W+2].
- Prediction (combinational, IF): hit = BTB valid & tag match.
  - pred_br = hit & counter MSB.
  - pred_pc = pred_br ? BTB target : pc_IF+4.
  - A counter MSB of 1 without a BTB hit gives no prediction.
- Record pipeline: DEPTH entries {valid, taken, target}.
  - Each cycle with !stall, it shifts one stage; stage 0 loads {1, pred_br, pred_pc}.
  - The EX record is the last stage.
  - stall: all entries hold.
  - Flush_B: all entries invalidated on the next edge, including the stage-0 load. Flush has priority over stall.
- Resolution (EX, combinational):
  - Actual target T = pc_EX+ext_EX, 32-bit wrap.
  - If the EX record is invalid, the prediction is taken = 0.
  - mispredict = is_B_EX & (rec.taken != real_br_EX | (real_br_EX & rec.target != T)).
  - Flush_B = mispredict & !stall.
  - br_pc is always driven; it is meaningful only when Flush_B = 1.
- Update, on the edge when is_B_EX & !stall, indexed by pc_EX:
  - Counter increments if real_br_EX, else decrements, saturating at 0 and 2**CNT_W-1.
  - If real_br_EX: BTB entry ← {valid = 1, tag(pc_EX), T}, replacing any alias.
  - Not-taken never invalidates a BTB entry.
  - br_count += 1; miss_count += mispredict. Both wrap modulo 2**STAT_W.
- Same-index read/write in one cycle: IF sees the pre-update value (read-before-write).
- Non-branch in EX (is_B_EX = 0): no flush, no table or statistics change.
- Reset mid-operation clears all state immediately; no flush is issued after release.

Test Plan:
- Reset, pc_IF = 0x100 → pred_br = 0, pred_pc = 0x104, Flush_B = 0, counters all 0.
- Cold branch, pc_EX = 0x100, ext_EX = -16, taken → Flush_B = 1, br_pc = 0xF0, miss_count = 1. Later fetch of 0x100 → pred_br = 1, pred_pc = 0xF0.
- Loop: same branch taken 5×, then not-taken (CNT_W = 2).
  - Counter saturates at 3, with no further flushes after training.
  - The not-taken resolution flushes with br_pc = 0x104; counter = 2 and pred_br stays 1.
- Alias: train 0x100 taken, then fetch 0x100 + 4·2**IDX_W → tag mismatch, pred_br = 0. A taken resolution there replaces the entry, so 0x100 then misses.
- Stall: mispredicting branch in EX with stall = 1 → Flush_B = 0, no counter or table change. Stall drops → Flush_B = 1 once, counts +1.
- Flush purge: mispredict → in-flight records invalid next cycle. A following is_B_EX with an invalid record is treated as predicted not-taken (taken branch flushes; not-taken does not).
